// File: rtl/axi_sram_slave.sv
// AXI4 responder over a single-port synchronous-read word RAM, serving one burst at a time.
// Optional feature macro AXI_SRAM_WRAP_EN: enables WRAP bursts of 2/4/8/16 beats.
module axi_sram_slave #(
    parameter int MEM_WORDS = 4096,
    parameter int ID_W      = 6
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [ID_W-1:0] aw_id,
    input  logic [31:0]     aw_addr,
    input  logic [7:0]      aw_len,
    input  logic [2:0]      aw_size,
    input  logic [1:0]      aw_burst,
    input  logic            aw_valid,
    output logic            aw_ready,
    input  logic [31:0]     w_data,
    input  logic [3:0]      w_strb,
    input  logic            w_last,
    input  logic            w_valid,
    output logic            w_ready,
    output logic [ID_W-1:0] b_id,
    output logic [1:0]      b_resp,
    output logic            b_valid,
    input  logic            b_ready,
    input  logic [ID_W-1:0] ar_id,
    input  logic [31:0]     ar_addr,
    input  logic [7:0]      ar_len,
    input  logic [2:0]      ar_size,
    input  logic [1:0]      ar_burst,
    input  logic            ar_valid,
    output logic            ar_ready,
    output logic [ID_W-1:0] r_id,
    output logic [31:0]     r_data,
    output logic [1:0]      r_resp,
    output logic            r_last,
    output logic            r_valid,
    input  logic            r_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_SRAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA} state_t;

    // Anything other than 32-bit beats with FIXED/INCR (or enabled WRAP) is handshaked but not serviced.
    function automatic logic unsupported(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len);
        logic lenOk;
        lenOk = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !(WRAP_EN && lenOk));
    endfunction

    function automatic logic [31:0] nextAddr(input logic [31:0] a, input logic [1:0] burst,
                                             input logic [7:0] len);
        logic [31:0] inc;
        logic [31:0] mask;
        logic [31:0] res;
        inc  = a + 32'd4;
        mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
        case (burst)
            2'b00:   res = a;
            2'b10:   res = (a & ~mask) | (inc & mask);
            default: res = inc;
        endcase
        return res;
    endfunction

    state_t          r_state;
    logic            r_writeNext;
    logic [ID_W-1:0] r_txnId;
    logic [31:0]     r_addr;
    logic [7:0]      r_len;
    logic [1:0]      r_burst;
    logic            r_unsup;
    logic [7:0]      r_beat;
    logic            r_overrun;
    logic [1:0]      r_bResp;
    logic            r_lastFlag;
    logic [31:0]     r_ramQ;
    logic [31:0]     r_mem [MEM_WORDS];

    logic            w_grantW;
    logic            w_grantR;
    logic            w_ramWe;
    logic [AW-1:0]   w_wordIdx;

    assign w_grantW  = aw_valid && (!ar_valid || r_writeNext);
    assign w_grantR  = ar_valid && !w_grantW;
    assign w_wordIdx = r_addr[AW+1:2];

    assign aw_ready = !areset && (r_state == IDLE) && w_grantW;
    assign ar_ready = !areset && (r_state == IDLE) && w_grantR;
    assign w_ready  = !areset && (r_state == WDATA);
    assign b_valid  = !areset && (r_state == WRESP);
    assign r_valid  = !areset && (r_state == RDATA);

    assign b_id   = r_txnId;
    assign r_id   = r_txnId;
    assign b_resp = r_bResp;
    assign r_last = r_lastFlag;
    assign r_resp = ((r_state == RDATA) && r_unsup) ? RESP_SLVERR : RESP_OKAY;
    assign r_data = ((r_state == RDATA) && !r_unsup) ? r_ramQ : 32'd0;

    // Beats past len+1 are swallowed; unsupported bursts never touch the array.
    assign w_ramWe = w_ready && w_valid && !r_unsup && !r_overrun;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_writeNext <= 1'b1;
            r_txnId     <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_burst     <= '0;
            r_unsup     <= 1'b0;
            r_beat      <= '0;
            r_overrun   <= 1'b0;
            r_bResp     <= RESP_OKAY;
            r_lastFlag  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (aw_ready) begin
                        r_txnId     <= aw_id;
                        r_addr      <= aw_addr;
                        r_len       <= aw_len;
                        r_burst     <= aw_burst;
                        r_unsup     <= unsupported(aw_size, aw_burst, aw_len);
                        r_beat      <= '0;
                        r_overrun   <= 1'b0;
                        r_writeNext <= 1'b0;
                        r_state     <= WDATA;
                    end else if (ar_ready) begin
                        r_txnId     <= ar_id;
                        r_addr      <= ar_addr;
                        r_len       <= ar_len;
                        r_burst     <= ar_burst;
                        r_unsup     <= unsupported(ar_size, ar_burst, ar_len);
                        r_beat      <= '0;
                        r_writeNext <= 1'b1;
                        r_state     <= RADDR;
                    end
                end
                WDATA: begin
                    if (w_valid) begin
                        if (!r_overrun) begin
                            if (r_beat == r_len) begin
                                r_overrun <= !w_last;
                            end else begin
                                r_beat <= r_beat + 8'd1;
                            end
                        end
                        r_addr <= nextAddr(r_addr, r_burst, r_len);
                        if (w_last) begin
                            r_bResp <= (r_unsup || r_overrun || (r_beat != r_len)) ? RESP_SLVERR : RESP_OKAY;
                            r_state <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (b_ready) begin
                        r_bResp <= RESP_OKAY;
                        r_state <= IDLE;
                    end
                end
                RADDR: begin
                    r_lastFlag <= (r_beat == r_len);
                    r_state    <= RDATA;
                end
                RDATA: begin
                    if (r_ready) begin
                        r_lastFlag <= 1'b0;
                        if (r_lastFlag) begin
                            r_state <= IDLE;
                        end else begin
                            r_addr  <= nextAddr(r_addr, r_burst, r_len);
                            r_beat  <= r_beat + 8'd1;
                            r_state <= RADDR;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The array is deliberately outside reset so contents survive an abandoned burst.
    always_ff @(posedge aclk) begin
        if (w_ramWe) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    r_mem[w_wordIdx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
        if (r_state == RADDR) begin
            r_ramQ <= r_mem[w_wordIdx];
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: transaction table driven through B/R scoreboards plus
// hand-written arbitration, stall, overrun/early-last and mid-burst reset sequences.
module tb_axi_sram_slave;
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] BADB  = 2'b11;
    localparam logic [1:0] OK    = 2'b00;
    localparam logic [1:0] SE    = 2'b10;

    typedef struct packed {
        logic            isWr;
        logic [5:0]      id;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [3:0][31:0] data;
        logic [3:0][3:0]  strb;
        logic [1:0]      resp;
    } vec_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } bexp_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    logic aclk = 1'b0;
    logic areset;
    logic [5:0] aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr, w_data, r_data;
    logic [7:0] aw_len, ar_len;
    logic [2:0] aw_size, ar_size;
    logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
    logic [3:0] w_strb;
    logic aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic ar_valid, ar_ready, r_last, r_valid, r_ready;

    int nCompared;
    int nMismatched;
    bexp_t bQ[$];
    rexp_t rQ[$];
    vec_t vecs[$];

    always #5 aclk = ~aclk;

    axi_sram_slave dut (
        .aclk(aclk), .areset(areset),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic sigHigh(input int which);
        case (which)
            0:       return aw_ready;
            1:       return w_ready;
            2:       return b_valid;
            3:       return ar_ready;
            default: return r_valid;
        endcase
    endfunction

    // Bounded wait; an expired bound is recorded as a failed comparison.
    task automatic waitHigh(input int which, output int n);
        n = 0;
        #1;
        while (!sigHigh(which) && n < 100) begin
            tick();
            #1;
            n++;
        end
        if (!sigHigh(which)) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL timeout on handshake signal %0d: got 0 required 1", which);
        end
    endtask

    function automatic vec_t mkVec(input logic isWr, input logic [5:0] id, input logic [31:0] addr,
                                   input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                   input logic [127:0] data, input logic [15:0] strb, input logic [1:0] resp);
        vec_t v;
        v.isWr = isWr; v.id = id; v.addr = addr; v.len = len; v.size = size;
        v.burst = burst; v.data = data; v.strb = strb; v.resp = resp;
        return v;
    endfunction

    task automatic doWrite(input vec_t v, input int nW);
        bexp_t e;
        int n;
        e.id = v.id;
        e.resp = v.resp;
        bQ.push_back(e);
        aw_id = v.id; aw_addr = v.addr; aw_len = v.len; aw_size = v.size; aw_burst = v.burst;
        aw_valid = 1'b1;
        waitHigh(0, n);
        tick();
        aw_valid = 1'b0;
        for (int b = 0; b < nW; b++) begin
            w_data  = v.data[2'(b)];
            w_strb  = v.strb[2'(b)];
            w_last  = (b == nW - 1);
            w_valid = 1'b1;
            waitHigh(1, n);
            tick();
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        b_ready = 1'b1;
        waitHigh(2, n);
        e = bQ.pop_front();
        checkOutput($sformatf("wr %02h b_id", v.id), 32'(b_id), 32'(e.id));
        checkOutput($sformatf("wr %02h b_resp", v.id), 32'(b_resp), 32'(e.resp));
        tick();
        b_ready = 1'b0;
    endtask

    task automatic doRead(input vec_t v, input int stallBeat);
        rexp_t e;
        int n;
        for (int b = 0; b <= int'(v.len); b++) begin
            e.id   = v.id;
            e.data = v.data[2'(b)];
            e.resp = v.resp;
            e.last = (b == int'(v.len));
            rQ.push_back(e);
        end
        ar_id = v.id; ar_addr = v.addr; ar_len = v.len; ar_size = v.size; ar_burst = v.burst;
        ar_valid = 1'b1;
        waitHigh(3, n);
        tick();
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        for (int b = 0; b <= int'(v.len); b++) begin
            waitHigh(4, n);
            if (b == 0) checkOutput($sformatf("rd %02h latency", v.id), 32'(n + 1), 32'd2);
            e = rQ[0];
            if (b == stallBeat) begin
                r_ready = 1'b0;
                repeat (5) begin
                    tick();
                    #1;
                    checkOutput("stall r_valid", 32'(r_valid), 32'd1);
                    checkOutput("stall r_data", r_data, e.data);
                    checkOutput("stall r_last", 32'(r_last), 32'(e.last));
                end
                r_ready = 1'b1;
            end
            e = rQ.pop_front();
            checkOutput($sformatf("rd %02h beat%0d r_id", v.id, b), 32'(r_id), 32'(e.id));
            checkOutput($sformatf("rd %02h beat%0d r_data", v.id, b), r_data, e.data);
            checkOutput($sformatf("rd %02h beat%0d r_resp", v.id, b), 32'(r_resp), 32'(e.resp));
            checkOutput($sformatf("rd %02h beat%0d r_last", v.id, b), 32'(r_last), 32'(e.last));
            tick();
        end
        r_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int nW, input int stallBeat);
        if (v.isWr) doWrite(v, nW);
        else        doRead(v, stallBeat);
    endtask

    // Both channels request together; write must win whenever the previous grant was a read.
    task automatic arbRound(input logic [31:0] wdata);
        int n;
        aw_id = 6'h2A; aw_addr = 32'h800; aw_len = 8'd0; aw_size = 3'd2; aw_burst = INCR;
        ar_id = 6'h15; ar_addr = 32'h800; ar_len = 8'd0; ar_size = 3'd2; ar_burst = INCR;
        aw_valid = 1'b1;
        ar_valid = 1'b1;
        #1;
        checkOutput("arb aw_ready first", 32'(aw_ready), 32'd1);
        checkOutput("arb ar_ready first", 32'(ar_ready), 32'd0);
        tick();
        aw_valid = 1'b0;
        w_data = wdata; w_strb = 4'hF; w_last = 1'b1; w_valid = 1'b1;
        waitHigh(1, n);
        checkOutput("arb ar_ready in write", 32'(ar_ready), 32'd0);
        tick();
        w_valid = 1'b0;
        w_last  = 1'b0;
        b_ready = 1'b1;
        waitHigh(2, n);
        checkOutput("arb b_id", 32'(b_id), 32'h2A);
        checkOutput("arb b_resp", 32'(b_resp), 32'(OK));
        tick();
        b_ready = 1'b0;
        #1;
        checkOutput("arb ar_ready second", 32'(ar_ready), 32'd1);
        tick();
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        waitHigh(4, n);
        checkOutput("arb rd latency", 32'(n + 1), 32'd2);
        checkOutput("arb r_id", 32'(r_id), 32'h15);
        checkOutput("arb r_data", r_data, wdata);
        checkOutput("arb r_last", 32'(r_last), 32'd1);
        tick();
        r_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        nCompared = 0;
        nMismatched = 0;
        areset = 1'b1;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b1;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b1;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
        b_ready = 1'b0; r_ready = 1'b0;
        repeat (3) tick();
        #1;
        checkOutput("reset aw_ready", 32'(aw_ready), 32'd0);
        checkOutput("reset ar_ready", 32'(ar_ready), 32'd0);
        checkOutput("reset w_ready", 32'(w_ready), 32'd0);
        checkOutput("reset b_valid", 32'(b_valid), 32'd0);
        checkOutput("reset r_valid", 32'(r_valid), 32'd0);
        checkOutput("reset b_resp", 32'(b_resp), 32'd0);
        checkOutput("reset r_resp", 32'(r_resp), 32'd0);
        checkOutput("reset r_last", 32'(r_last), 32'd0);
        checkOutput("reset r_data", r_data, 32'd0);
        checkOutput("reset b_id", 32'(b_id), 32'd0);
        checkOutput("reset r_id", 32'(r_id), 32'd0);
        aw_valid = 1'b0;
        ar_valid = 1'b0;
        tick();
        areset = 1'b0;
        tick();

        arbRound(32'h5A5A0000);
        arbRound(32'h5A5A0001);

        vecs.push_back(mkVec(1, 6'h01, 32'h100, 0, 2, INCR, {96'd0, 32'hDEADBEEF}, 16'h000F, OK));
        vecs.push_back(mkVec(0, 6'h01, 32'h100, 0, 2, INCR, {96'd0, 32'hDEADBEEF}, 16'h0, OK));
        vecs.push_back(mkVec(1, 6'h02, 32'h200, 3, 2, INCR, {4{32'hFFFFFFFF}}, 16'hFFFF, OK));
        vecs.push_back(mkVec(1, 6'h03, 32'h200, 3, 2, INCR, {32'd4, 32'd3, 32'd2, 32'd1}, 16'hFF3F, OK));
        vecs.push_back(mkVec(0, 6'h03, 32'h200, 3, 2, INCR, {32'd4, 32'd3, 32'hFFFF0002, 32'd1}, 16'h0, OK));
        vecs.push_back(mkVec(1, 6'h04, 32'h4010, 0, 2, INCR, {96'd0, 32'hCAFEF00D}, 16'h000F, OK));
        vecs.push_back(mkVec(0, 6'h04, 32'h10, 0, 2, INCR, {96'd0, 32'hCAFEF00D}, 16'h0, OK));
        vecs.push_back(mkVec(1, 6'h05, 32'h40, 2, 2, FIXED, {32'd0, 32'hC, 32'hB, 32'hA}, 16'h0FFF, OK));
        vecs.push_back(mkVec(0, 6'h05, 32'h40, 2, 2, FIXED, {32'd0, 32'hC, 32'hC, 32'hC}, 16'h0, OK));
        vecs.push_back(mkVec(1, 6'h06, 32'h100, 1, 1, INCR, {64'd0, {2{32'h11111111}}}, 16'h00FF, SE));
        vecs.push_back(mkVec(0, 6'h06, 32'h100, 0, 2, INCR, {96'd0, 32'hDEADBEEF}, 16'h0, OK));
        vecs.push_back(mkVec(0, 6'h06, 32'h100, 1, 1, INCR, 128'd0, 16'h0, SE));
        vecs.push_back(mkVec(1, 6'h07, 32'h200, 0, 2, BADB, {96'd0, 32'h99}, 16'h000F, SE));
        vecs.push_back(mkVec(0, 6'h07, 32'h200, 0, 2, INCR, {96'd0, 32'd1}, 16'h0, OK));
        vecs.push_back(mkVec(0, 6'h07, 32'h200, 0, 2, BADB, 128'd0, 16'h0, SE));
        vecs.push_back(mkVec(1, 6'h09, 32'h300, 3, 2, INCR, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF, OK));
`ifdef AXI_SRAM_WRAP_EN
        vecs.push_back(mkVec(1, 6'h08, 32'h30C, 3, 2, WRAP, {32'h40, 32'h30, 32'h20, 32'h10}, 16'hFFFF, OK));
        vecs.push_back(mkVec(0, 6'h08, 32'h300, 3, 2, INCR, {32'h10, 32'h40, 32'h30, 32'h20}, 16'h0, OK));
        vecs.push_back(mkVec(0, 6'h08, 32'h30C, 3, 2, WRAP, {32'h40, 32'h30, 32'h20, 32'h10}, 16'h0, OK));
`else
        vecs.push_back(mkVec(1, 6'h08, 32'h30C, 3, 2, WRAP, {32'h40, 32'h30, 32'h20, 32'h10}, 16'hFFFF, SE));
        vecs.push_back(mkVec(0, 6'h08, 32'h300, 3, 2, INCR, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'h0, OK));
        vecs.push_back(mkVec(0, 6'h08, 32'h30C, 3, 2, WRAP, 128'd0, 16'h0, SE));
`endif
        vecs.push_back(mkVec(1, 6'h0A, 32'h600, 3, 2, INCR, {4{32'hEEEEEEEE}}, 16'hFFFF, OK));
        vecs.push_back(mkVec(1, 6'h0A, 32'h700, 3, 2, INCR, {4{32'hEEEEEEEE}}, 16'hFFFF, OK));
        vecs.push_back(mkVec(1, 6'h0A, 32'hA08, 0, 2, INCR, {96'd0, 32'h12345678}, 16'h000F, OK));

        foreach (vecs[i]) applyStimulus(vecs[i], int'(vecs[i].len) + 1, -1);

        // Backpressure on the middle beat of a 3-beat read.
        applyStimulus(mkVec(0, 6'h0E, 32'h200, 2, 2, INCR, {32'd0, 32'd3, 32'hFFFF0002, 32'd1}, 16'h0, OK), 0, 1);

        // Two extra beats past len+1 are accepted but not written.
        applyStimulus(mkVec(1, 6'h0B, 32'h600, 1, 2, INCR, {32'h44, 32'h33, 32'h22, 32'h11}, 16'hFFFF, SE), 4, -1);
        applyStimulus(mkVec(0, 6'h0B, 32'h600, 3, 2, INCR, {{2{32'hEEEEEEEE}}, 32'h22, 32'h11}, 16'h0, OK), 0, -1);

        // w_last after two beats of a four-beat burst.
        applyStimulus(mkVec(1, 6'h0C, 32'h700, 3, 2, INCR, {64'd0, 32'h66, 32'h55}, 16'hFFFF, SE), 2, -1);
        applyStimulus(mkVec(0, 6'h0C, 32'h700, 0, 2, INCR, {96'd0, 32'h55}, 16'h0, OK), 0, -1);
        applyStimulus(mkVec(0, 6'h0C, 32'h708, 1, 2, INCR, {64'd0, {2{32'hEEEEEEEE}}}, 16'h0, OK), 0, -1);

        // Reset lands while the third beat of a four-beat write is being offered.
        aw_id = 6'h0D; aw_addr = 32'hA00; aw_len = 8'd3; aw_size = 3'd2; aw_burst = INCR;
        aw_valid = 1'b1;
        waitHigh(0, n);
        tick();
        aw_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            w_data = (b == 0) ? 32'h77777777 : 32'h88888888;
            w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
            waitHigh(1, n);
            tick();
        end
        w_data = 32'h99999999;
        areset = 1'b1;
        #1;
        checkOutput("midreset w_ready", 32'(w_ready), 32'd0);
        checkOutput("midreset b_valid", 32'(b_valid), 32'd0);
        tick();
        w_valid = 1'b0;
        #1;
        checkOutput("midreset b_valid held", 32'(b_valid), 32'd0);
        checkOutput("midreset b_resp", 32'(b_resp), 32'd0);
        tick();
        areset = 1'b0;
        tick();
        checkOutput("postreset b_valid", 32'(b_valid), 32'd0);
        aw_id = 6'h0F; aw_addr = 32'hB00; aw_len = 8'd0;
        aw_valid = 1'b1;
        #1;
        checkOutput("postreset aw_ready", 32'(aw_ready), 32'd1);
        aw_valid = 1'b0;
        tick();
        applyStimulus(mkVec(0, 6'h0D, 32'hA00, 2, 2, INCR, {32'd0, 32'h12345678, 32'h88888888, 32'h77777777}, 16'h0, OK), 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
